// File: rtl/dmem_ctrl.sv
// Load/store controller for a single-port 32-bit block RAM: takes one byte/half/word
// request at a time, runs the RAM cycle with lane steering and returns extended read data.
module dmem_ctrl #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W+1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic                mem_ce,
    output logic                mem_oce,
    output logic                mem_reset,
    output logic                mem_wre,
    output logic [ADDR_W-1:0]   mem_ad,
    output logic [3:0]          mem_byte_en,
    output logic [31:0]         mem_din,
    input  logic [31:0]         mem_dout
);

    localparam int unsigned BA_W = ADDR_W + 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic            we_q;
    logic            uns_q;
    logic [BA_W-1:0] addr_q;
    logic [1:0]      size_q;
    logic [31:0]     wdata_q;

    logic        accept_c;
    logic        misaligned_c;
    logic [31:0] shifted_c;
    logic [31:0] load_data_c;
    logic [3:0]  byte_en_c;
    logic [31:0] din_c;

    assign accept_c = req_valid && (state_q == IDLE);

    // Illegal size or an address not aligned to the access size
    always_comb begin
        misaligned_c = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned_c = 1'b0;
            SZ_HALF: misaligned_c = req_addr[0];
            SZ_WORD: misaligned_c = |req_addr[1:0];
            default: misaligned_c = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = misaligned_c ? RESP : ISSUE;
            ISSUE:   state_d = we_q ? RESP : READ;
            READ:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request fields and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            size_q    <= SZ_BYTE;
            wdata_q   <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= (state_d == RESP);
            if (accept_c) begin
                we_q      <= req_we;
                uns_q     <= req_unsigned;
                addr_q    <= req_addr;
                size_q    <= req_size;
                wdata_q   <= req_wdata;
                rsp_err   <= misaligned_c;
                rsp_rdata <= 32'h0;
            end
            if (state_q == READ) begin
                rsp_rdata <= load_data_c;
            end
        end
    end

    // Load extraction: align the addressed lane to bit 0, then extend
    assign shifted_c = mem_dout >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data_c = shifted_c;
        case (size_q)
            SZ_BYTE: load_data_c = uns_q ? {24'h0, shifted_c[7:0]}
                                         : {{24{shifted_c[7]}}, shifted_c[7:0]};
            SZ_HALF: load_data_c = uns_q ? {16'h0, shifted_c[15:0]}
                                         : {{16{shifted_c[15]}}, shifted_c[15:0]};
            default: load_data_c = shifted_c;
        endcase
    end

    // Store lane steering; loads read the whole word
    always_comb begin
        byte_en_c = 4'b1111;
        din_c     = wdata_q;
        if (we_q) begin
            case (size_q)
                SZ_BYTE: begin
                    byte_en_c = 4'(4'b0001 << addr_q[1:0]);
                    din_c     = {4{wdata_q[7:0]}};
                end
                SZ_HALF: begin
                    byte_en_c = addr_q[1] ? 4'b1100 : 4'b0011;
                    din_c     = {2{wdata_q[15:0]}};
                end
                default: begin
                    byte_en_c = 4'b1111;
                    din_c     = wdata_q;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign mem_ce      = (state_q == ISSUE) && !reset;
    assign mem_oce     = mem_ce;
    assign mem_reset   = reset;
    assign mem_wre     = mem_ce && we_q;
    assign mem_ad      = addr_q[BA_W-1:2];
    assign mem_byte_en = (state_q == ISSUE) ? byte_en_c : 4'b0000;
    assign mem_din     = din_c;

endmodule
